seq_stim_ctrl: RTL and testbench
================================

// Module: seq_stim_ctrl
// PURPOSE
//  Parametrised stimulus/control generator for the sequence-detector datapath.
//  Produces a serial input_bit stream in one of four modes (toggle, pattern rotate, LFSR, hold).
//  Tracks a modulo-NUM_STATES state index that advances on seq_rdy qualified by input_bit.
//  Emits a periodic single-cycle data_ack strobe and wrap pulses for the bench and downstream checkers.
// PARAMETERS
//  NUM_STATES  4      state index modulus (>=2)
//  STATE_W     2      width of current_state (>= clog2(NUM_STATES))
//  PAT_W       8      width of pattern / working register (>=2)
//  TAPS        8'hB8  Galois LFSR feedback mask, PAT_W bits
//  ACK_PERIOD  8      data_ack period in enabled cycles (>=1)
//  CNT_W       4      ack counter width (>= clog2(ACK_PERIOD))
// PORTS
//  clk            in   1        clock, rising edge
//  rst_n          in   1        reset, asynchronous, active-low
//  en             in   1        advance enable; low = freeze all state
//  mode           in   2        00 toggle, 01 pattern rotate, 10 LFSR, 11 hold
//  load           in   1        synchronous load of pattern, restart of counters
//  pattern        in   PAT_W    value loaded into working register on load
//  seq_rdy        in   1        downstream ready; qualifies the state advance
//  input_bit      out  1        serial stimulus bit = wreg[0] (registered)
//  current_state  out  STATE_W  state index, 0..NUM_STATES-1
//  data_ack       out  1        one-cycle strobe every ACK_PERIOD enabled cycles
//  state_wrap     out  1        one-cycle pulse when current_state wraps to 0
//  pattern_wrap   out  1        one-cycle pulse after PAT_W rotations in mode 01
// BEHAVIOUR
//  Reset: wreg=1 (input_bit=1), current_state=NUM_STATES-1, ack_cnt=0, bit_idx=0; all pulse outputs 0.
//  Priority per edge: load > en > idle.
//  load=1 (en ignored):
//    - wreg<=pattern, current_state<=NUM_STATES-1, ack_cnt<=0, bit_idx<=0
//    - data_ack, state_wrap and pattern_wrap all 0
//  en=1, load=0, per edge; all terms use pre-edge values:
//    - mode 00: wreg[0]<=~wreg[0]; upper bits unchanged
//    - mode 01: wreg rotates right by 1; bit_idx wraps PAT_W-1 -> 0
//    - mode 01: pattern_wrap<=1 on the edge where bit_idx goes PAT_W-1 -> 0, else 0
//    - mode 10: wreg<=(wreg>>1)^(wreg[0]?TAPS:0); if wreg==0, wreg<=1 (lock-up recovery)
//    - mode 11: wreg unchanged
//    - seq_rdy && input_bit: current_state+1, wrapping NUM_STATES-1 -> 0
//    - state_wrap<=1 on that wrap edge, else 0
//    - data_ack<=(ack_cnt==0); ack_cnt+1, wrapping ACK_PERIOD-1 -> 0
//  en=0, load=0: wreg, current_state, ack_cnt and bit_idx hold; all three pulses are 0.
//  bit_idx advances only in mode 01 and holds in the other modes.
//  A mode change takes effect on the next edge; wreg is never cleared by a mode change.
//  Latency: input_bit and state updates are visible 1 cycle after the qualifying edge.
//  Async reset mid-run restores reset values immediately, independent of clk.
//  ACK_PERIOD=1: data_ack stays high on every enabled cycle.
// TESTING
//  T1 reset, en=1, mode=00, seq_rdy=1
//     -> current_state after edges 1..6 = 0,0,1,1,2,2
//     -> input_bit after edges 1..6 = 0,1,0,1,0,1
//     -> state_wrap high only after edge 1
//  T2 en=1 from reset, ACK_PERIOD=8
//     -> data_ack high only after edges 1, 9, 17
//     -> drop en for 3 cycles: strobe slips by 3, to edge 20 rather than edge 17
//  T3 load pattern=8'hB1, then mode=01, en=1
//     -> input_bit=1, then 0,0,0,1,1,0,1,1 after edges 1..8
//     -> pattern_wrap high after edge 8
//  T4 load pattern=8'h01, then mode=10, en=1
//     -> wreg sequence 01,B8,5C,2E,17,B3
//     -> load 8'h00 in mode 10 -> wreg=01 after the next enabled edge
//  T5 load=1 and en=1 on the same edge, with seq_rdy=1, input_bit=1, ack_cnt=0
//     -> no advance, data_ack=0, current_state=NUM_STATES-1
//  T6 assert rst_n=0 between edges while state=2, wreg=5C
//     -> outputs hold reset values immediately and on the first edge after release

Source files
------------

// File: rtl/seq_stim_ctrl.sv
// Stimulus/control generator for the sequence-detector datapath: serial bit stream in four
// modes, modulo state index advanced by seq_rdy & input_bit, periodic ack strobe and wrap pulses.
module seq_stim_ctrl #(
    parameter int               NUM_STATES = 4,
    parameter int               STATE_W    = 2,
    parameter int               PAT_W      = 8,
    parameter logic [PAT_W-1:0] TAPS       = 8'hB8,
    parameter int               ACK_PERIOD = 8,
    parameter int               CNT_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [PAT_W-1:0]   pattern,
    input  logic               seq_rdy,
    output logic               input_bit,
    output logic [STATE_W-1:0] current_state,
    output logic               data_ack,
    output logic               state_wrap,
    output logic               pattern_wrap
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    localparam logic [STATE_W-1:0] STATE_LAST = STATE_W'(NUM_STATES - 1);
    localparam logic [CNT_W-1:0]   ACK_LAST   = CNT_W'(ACK_PERIOD - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_LFSR   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [PAT_W-1:0]   wreg_q, wreg_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic               data_ack_q, data_ack_d;
    logic               state_wrap_q, state_wrap_d;
    logic               pattern_wrap_q, pattern_wrap_d;

    always_comb begin
        wreg_d         = wreg_q;
        state_d        = state_q;
        ack_cnt_d      = ack_cnt_q;
        bit_idx_d      = bit_idx_q;
        data_ack_d     = 1'b0;
        state_wrap_d   = 1'b0;
        pattern_wrap_d = 1'b0;

        if (load) begin
            wreg_d    = pattern;
            state_d   = STATE_LAST;
            ack_cnt_d = '0;
            bit_idx_d = '0;
        end else if (en) begin
            unique case (mode_e'(mode))
                MODE_TOGGLE: wreg_d[0] = ~wreg_q[0];
                MODE_ROTATE: begin
                    wreg_d = {wreg_q[0], wreg_q[PAT_W-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d      = '0;
                        pattern_wrap_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                // An all-zero register would lock the LFSR forever, so reseed it with 1.
                MODE_LFSR: begin
                    if (wreg_q == '0) wreg_d = PAT_W'(1);
                    else              wreg_d = (wreg_q >> 1) ^ (wreg_q[0] ? TAPS : '0);
                end
                MODE_HOLD: wreg_d = wreg_q;
                default:   wreg_d = wreg_q;
            endcase

            if (seq_rdy && wreg_q[0]) begin
                if (state_q == STATE_LAST) begin
                    state_d      = '0;
                    state_wrap_d = 1'b1;
                end else begin
                    state_d = state_q + 1'b1;
                end
            end

            data_ack_d = (ack_cnt_q == '0);
            ack_cnt_d  = (ack_cnt_q == ACK_LAST) ? '0 : ack_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wreg_q         <= PAT_W'(1);
            state_q        <= STATE_LAST;
            ack_cnt_q      <= '0;
            bit_idx_q      <= '0;
            data_ack_q     <= 1'b0;
            state_wrap_q   <= 1'b0;
            pattern_wrap_q <= 1'b0;
        end else begin
            wreg_q         <= wreg_d;
            state_q        <= state_d;
            ack_cnt_q      <= ack_cnt_d;
            bit_idx_q      <= bit_idx_d;
            data_ack_q     <= data_ack_d;
            state_wrap_q   <= state_wrap_d;
            pattern_wrap_q <= pattern_wrap_d;
        end
    end

    assign input_bit     = wreg_q[0];
    assign current_state = state_q;
    assign data_ack      = data_ack_q;
    assign state_wrap    = state_wrap_q;
    assign pattern_wrap  = pattern_wrap_q;

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Directed bench for seq_stim_ctrl: default instance plus an ACK_PERIOD=1 instance on shared inputs.
module tb_seq_stim_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [7:0] pattern;
    logic       seq_rdy;

    logic       input_bit, data_ack, state_wrap, pattern_wrap;
    logic [1:0] current_state;
    logic       input_bit1, data_ack1, state_wrap1, pattern_wrap1;
    logic [1:0] current_state1;

    int n_checks = 0;
    int n_pass   = 0;

    seq_stim_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .pattern(pattern),
        .seq_rdy(seq_rdy), .input_bit(input_bit), .current_state(current_state),
        .data_ack(data_ack), .state_wrap(state_wrap), .pattern_wrap(pattern_wrap)
    );

    seq_stim_ctrl #(.ACK_PERIOD(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .pattern(pattern),
        .seq_rdy(seq_rdy), .input_bit(input_bit1), .current_state(current_state1),
        .data_ack(data_ack1), .state_wrap(state_wrap1), .pattern_wrap(pattern_wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge, return at the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; load = 1'b0; mode = 2'b00; pattern = '0; seq_rdy = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    int         exp_st[6] = '{0, 0, 1, 1, 2, 2};
    logic       exp_ib[6] = '{0, 1, 0, 1, 0, 1};
    logic       exp_rot[8] = '{0, 0, 0, 1, 1, 0, 1, 1};
    logic [7:0] exp_lfsr[5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

    initial begin
        @(negedge clk);
        do_reset();

        chk("rst_input_bit", input_bit, 1);
        chk("rst_state", current_state, 3);
        chk("rst_data_ack", data_ack, 0);
        chk("rst_state_wrap", state_wrap, 0);
        chk("rst_pattern_wrap", pattern_wrap, 0);

        // T1: toggle mode with seq_rdy high
        en = 1'b1; mode = 2'b00; seq_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t1_state_e%0d", i + 1), current_state, exp_st[i]);
            chk($sformatf("t1_bit_e%0d", i + 1), input_bit, exp_ib[i]);
            chk($sformatf("t1_wrap_e%0d", i + 1), state_wrap, (i == 0));
        end

        // T2: ack strobe period, with a 3-edge enable gap
        do_reset();
        mode = 2'b11; seq_rdy = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            en = !(e >= 17 && e <= 19);
            step();
            chk($sformatf("t2_ack_e%0d", e), data_ack, (e == 1 || e == 9 || e == 20));
            chk($sformatf("t2_ack1_e%0d", e), data_ack1, en);
        end
        chk("t2_state_hold", current_state, 3);

        // T3: rotate pattern B1
        load = 1'b1; pattern = 8'hB1; en = 1'b0;
        step();
        load = 1'b0;
        chk("t3_load_bit", input_bit, 1);
        chk("t3_load_state", current_state, 3);
        mode = 2'b01; en = 1'b1; seq_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t3_bit_e%0d", i + 1), input_bit, exp_rot[i]);
            chk($sformatf("t3_pwrap_e%0d", i + 1), pattern_wrap, (i == 7));
        end

        // T4: LFSR from 01, then zero lock-up recovery
        en = 1'b0; load = 1'b1; pattern = 8'h01;
        step();
        load = 1'b0; mode = 2'b10; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t4_wreg_e%0d", i + 1), dut.wreg_q, exp_lfsr[i]);
            chk($sformatf("t4_bit_e%0d", i + 1), input_bit, exp_lfsr[i][0]);
        end
        en = 1'b0; load = 1'b1; pattern = 8'h00;
        step();
        load = 1'b0;
        chk("t4_zero_loaded", dut.wreg_q, 8'h00);
        en = 1'b1;
        step();
        chk("t4_recover", dut.wreg_q, 8'h01);

        // T5: load wins over en on the same edge
        do_reset();
        load = 1'b1; en = 1'b1; seq_rdy = 1'b1; mode = 2'b00; pattern = 8'hFF;
        step();
        load = 1'b0; en = 1'b0;
        chk("t5_state", current_state, 3);
        chk("t5_ack", data_ack, 0);
        chk("t5_ack1", data_ack1, 0);
        chk("t5_wrap", state_wrap, 0);
        chk("t5_bit", input_bit, 1);

        // T6: async reset mid-run with state=2, wreg=5C
        load = 1'b1; pattern = 8'hB9;
        step();
        load = 1'b0; mode = 2'b11; en = 1'b1; seq_rdy = 1'b1;
        repeat (3) step();
        mode = 2'b00; seq_rdy = 1'b0;
        step();
        mode = 2'b10;
        step();
        en = 1'b0;
        chk("t6_pre_state", current_state, 2);
        chk("t6_pre_wreg", dut.wreg_q, 8'h5C);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_state", current_state, 3);
        chk("t6_async_bit", input_bit, 1);
        chk("t6_async_ack", data_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6_post_state", current_state, 3);
        chk("t6_post_wreg", dut.wreg_q, 8'h01);
        chk("t6_post_wrap", state_wrap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
